// File: rtl/snake_stepper.sv
// Snake game stepper: clears the map, draws the initial snake, then on each tick
// reads the next head cell and writes head/tail updates back to the map.
module snake_stepper #(
  parameter int MAPA_WIDTH  = 40,
  parameter int MAPA_HEIGHT = 30,
  parameter int MAX_LEN     = 64,
  parameter int INIT_X      = 20,
  parameter int INIT_Y      = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [1:0] dir,
  output logic       update_renable,
  output logic [9:0] update_rx,
  output logic [9:0] update_ry,
  input  logic [1:0] update_rdata,
  output logic       update_wenable,
  output logic [9:0] update_wx,
  output logic [9:0] update_wy,
  output logic [1:0] update_wdata,
  output logic       busy,
  output logic       fruit_eaten,
  output logic       game_over,
  output logic [7:0] score,
  output logic [6:0] length
);

  localparam int PW = $clog2(MAX_LEN);
  localparam logic [5:0] XMAX    = 6'(MAPA_WIDTH - 1);
  localparam logic [4:0] YMAX    = 5'(MAPA_HEIGHT - 1);
  localparam logic [5:0] XFIRST  = 6'(INIT_X - 2);
  localparam logic [4:0] YINIT   = 5'(INIT_Y);
  localparam logic [6:0] LEN_MAX = 7'(MAX_LEN);

  typedef enum logic [3:0] {
    CLEAR, DRAW, IDLE, READ, WAIT, EVAL, WHEAD, WTAIL, DEAD
  } state_t;

  state_t        state_q;
  logic [5:0]    cx_q, headX_q, nextX_q, rx_q, wx_q;
  logic [4:0]    cy_q, headY_q, nextY_q, ry_q, wy_q;
  logic [1:0]    drawCnt_q, curDir_q, cell_q, wdata_q;
  logic          grow_q, renable_q, wenable_q, fruit_q, over_q;
  logic [PW-1:0] wrPtr_q, rdPtr_q;
  logic [7:0]    score_q;
  logic [6:0]    len_q;
  logic [10:0]   queue_q [MAX_LEN];

  logic [1:0]    nextDir_d;
  logic [5:0]    stepX_d, drawX_d;
  logic [4:0]    stepY_d;
  logic          reversal_d, pushEn_d;
  logic [10:0]   pushCell_d, tailCell_d;

  // A request for the exact opposite of the current heading keeps the heading.
  always_comb begin
    reversal_d = (dir == (curDir_q ^ 2'b10));
    nextDir_d  = reversal_d ? curDir_q : dir;
    stepX_d    = headX_q;
    stepY_d    = headY_q;
    case (nextDir_d)
      2'b00:   stepX_d = (headX_q == XMAX) ? 6'd0 : headX_q + 6'd1;
      2'b01:   stepY_d = (headY_q == YMAX) ? 5'd0 : headY_q + 5'd1;
      2'b10:   stepX_d = (headX_q == 6'd0) ? XMAX : headX_q - 6'd1;
      default: stepY_d = (headY_q == 5'd0) ? YMAX : headY_q - 5'd1;
    endcase
  end

  assign drawX_d    = XFIRST + {4'b0000, drawCnt_q};
  assign pushEn_d   = (state_q == DRAW) || (state_q == WHEAD);
  assign pushCell_d = (state_q == DRAW) ? {drawX_d, YINIT} : {nextX_q, nextY_q};
  assign tailCell_d = queue_q[rdPtr_q];

  // The push lands on the same edge the tail is read, so a full queue still erases the old tail.
  always_ff @(posedge clk) begin
    if (pushEn_d) queue_q[wrPtr_q] <= pushCell_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= CLEAR;
      cx_q      <= '0;
      cy_q      <= '0;
      drawCnt_q <= '0;
      curDir_q  <= '0;
      headX_q   <= '0;
      headY_q   <= '0;
      nextX_q   <= '0;
      nextY_q   <= '0;
      cell_q    <= '0;
      grow_q    <= 1'b0;
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      renable_q <= 1'b0;
      rx_q      <= '0;
      ry_q      <= '0;
      wenable_q <= 1'b0;
      wx_q      <= '0;
      wy_q      <= '0;
      wdata_q   <= 2'b00;
      fruit_q   <= 1'b0;
      over_q    <= 1'b0;
      score_q   <= '0;
      len_q     <= '0;
    end else begin
      renable_q <= 1'b0;
      wenable_q <= 1'b0;
      wdata_q   <= 2'b00;
      fruit_q   <= 1'b0;
      case (state_q)
        CLEAR: begin
          wenable_q <= 1'b1;
          wx_q      <= cx_q;
          wy_q      <= cy_q;
          if (cx_q == XMAX) begin
            cx_q <= '0;
            if (cy_q == YMAX) begin
              cy_q    <= '0;
              state_q <= DRAW;
            end else begin
              cy_q <= cy_q + 5'd1;
            end
          end else begin
            cx_q <= cx_q + 6'd1;
          end
        end
        DRAW: begin
          wenable_q <= 1'b1;
          wx_q      <= drawX_d;
          wy_q      <= YINIT;
          wdata_q   <= 2'b01;
          headX_q   <= drawX_d;
          headY_q   <= YINIT;
          wrPtr_q   <= wrPtr_q + 1'b1;
          len_q     <= len_q + 7'd1;
          drawCnt_q <= drawCnt_q + 2'd1;
          if (drawCnt_q == 2'd2) state_q <= IDLE;
        end
        IDLE: begin
          if (tick) begin
            curDir_q  <= nextDir_d;
            nextX_q   <= stepX_d;
            nextY_q   <= stepY_d;
            renable_q <= 1'b1;
            rx_q      <= stepX_d;
            ry_q      <= stepY_d;
            state_q   <= READ;
          end
        end
        READ: state_q <= WAIT;
        WAIT: begin
          cell_q  <= update_rdata;
          fruit_q <= (update_rdata == 2'b10);
          state_q <= EVAL;
        end
        EVAL: begin
          // Body (01) and obstacle (11) both have bit 0 set.
          if (cell_q[0]) begin
            over_q  <= 1'b1;
            state_q <= DEAD;
          end else begin
            grow_q <= cell_q[1];
            if (cell_q[1] && (score_q != 8'hFF)) score_q <= score_q + 8'd1;
            wenable_q <= 1'b1;
            wx_q      <= nextX_q;
            wy_q      <= nextY_q;
            wdata_q   <= 2'b01;
            state_q   <= WHEAD;
          end
        end
        WHEAD: begin
          headX_q <= nextX_q;
          headY_q <= nextY_q;
          wrPtr_q <= wrPtr_q + 1'b1;
          if (!grow_q || (len_q == LEN_MAX)) begin
            wenable_q <= 1'b1;
            wx_q      <= tailCell_d[10:5];
            wy_q      <= tailCell_d[4:0];
            wdata_q   <= 2'b00;
            rdPtr_q   <= rdPtr_q + 1'b1;
          end else begin
            len_q <= len_q + 7'd1;
          end
          state_q <= WTAIL;
        end
        WTAIL:   state_q <= IDLE;
        DEAD:    state_q <= DEAD;
        default: state_q <= CLEAR;
      endcase
    end
  end

  assign update_renable = renable_q;
  assign update_rx      = {4'b0000, rx_q};
  assign update_ry      = {5'b00000, ry_q};
  assign update_wenable = wenable_q;
  assign update_wx      = {4'b0000, wx_q};
  assign update_wy      = {5'b00000, wy_q};
  assign update_wdata   = wdata_q;
  assign busy           = (state_q != IDLE) && (state_q != DEAD);
  assign fruit_eaten    = fruit_q;
  assign game_over      = over_q;
  assign score          = score_q;
  assign length         = len_q;

endmodule

// File: tb/tb_snake_stepper.sv
// Directed bench for snake_stepper: a small snake model predicts read/write
// coordinates, growth, score and death for every step.
module tb_snake_stepper;

  logic       clk = 1'b0;
  logic       rstN;
  logic       tick;
  logic [1:0] dirIn;
  logic [1:0] respVal;
  logic [1:0] rdataQ = 2'b00;
  logic       update_renable, update_wenable, busy, fruit_eaten, game_over;
  logic [9:0] update_rx, update_ry, update_wx, update_wy;
  logic [1:0] update_wdata;
  logic [7:0] score;
  logic [6:0] length;

  int vectors = 0;
  int miscompares = 0;

  // Snake model: body[0] is the tail, the last entry is the head.
  int mBodyX[$];
  int mBodyY[$];
  int mDir;
  int mScore;
  bit mDead;

  logic [5:0] rEnV, wEnV, feV;
  logic [9:0] rdX, rdY, hwX, hwY, twX, twY;
  logic [1:0] hwD, twD;

  snake_stepper dut (
    .clk(clk), .reset(rstN), .tick(tick), .dir(dirIn),
    .update_renable(update_renable), .update_rx(update_rx), .update_ry(update_ry),
    .update_rdata(rdataQ),
    .update_wenable(update_wenable), .update_wx(update_wx), .update_wy(update_wy),
    .update_wdata(update_wdata),
    .busy(busy), .fruit_eaten(fruit_eaten), .game_over(game_over),
    .score(score), .length(length)
  );

  always #5 clk = ~clk;

  // Map stand-in: answers a read one cycle after the strobe.
  always @(posedge clk) rdataQ <= update_renable ? respVal : 2'b00;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ren"}, update_renable, 0);
    checkOutput({tag, "_wen"}, update_wenable, 0);
    checkOutput({tag, "_wdata"}, update_wdata, 0);
    checkOutput({tag, "_wx"}, update_wx, 0);
    checkOutput({tag, "_busy"}, busy, 1);
    checkOutput({tag, "_len"}, length, 0);
    checkOutput({tag, "_score"}, score, 0);
    checkOutput({tag, "_over"}, game_over, 0);
    checkOutput({tag, "_fruit"}, fruit_eaten, 0);
  endtask

  // Runs from reset release through clear and draw, checking every map write.
  task automatic runClear();
    int zeroCnt = 0;
    int oneCnt = 0;
    int orderErr = 0;
    int oneX[3];
    int oneY[3];
    for (int i = 0; i < 1205; i++) begin
      @(negedge clk);
      if (update_wenable) begin
        if (update_wdata == 2'b00) begin
          if (update_wx != (zeroCnt % 40) || update_wy != (zeroCnt / 40)) orderErr++;
          zeroCnt++;
        end else if (update_wdata == 2'b01) begin
          if (oneCnt < 3) begin
            oneX[oneCnt] = int'(update_wx);
            oneY[oneCnt] = int'(update_wy);
          end
          oneCnt++;
        end
      end
    end
    checkOutput("clearCount", zeroCnt, 1200);
    checkOutput("clearOrder", orderErr, 0);
    checkOutput("drawCount", oneCnt, 3);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("draw%0d_x", k), oneX[k], 18 + k);
      checkOutput($sformatf("draw%0d_y", k), oneY[k], 15);
    end
    checkOutput("drawBusy", busy, 0);
    checkOutput("drawLen", length, 3);
    mBodyX = '{18, 19, 20};
    mBodyY = '{15, 15, 15};
    mDir = 0;
    mScore = 0;
    mDead = 1'b0;
  endtask

  // One tick, then six cycles of outputs captured at negedge (cycles N+1..N+6).
  task automatic applyStimulus(input logic [1:0] d, input logic [1:0] resp);
    @(negedge clk);
    tick = 1'b1;
    dirIn = d;
    respVal = resp;
    @(posedge clk);
    @(negedge clk);
    tick = 1'b0;
    for (int k = 0; k < 6; k++) begin
      rEnV[k] = update_renable;
      wEnV[k] = update_wenable;
      feV[k]  = fruit_eaten;
      if (k == 0) begin rdX = update_rx; rdY = update_ry; end
      if (k == 3) begin hwX = update_wx; hwY = update_wy; hwD = update_wdata; end
      if (k == 4) begin twX = update_wx; twY = update_wy; twD = update_wdata; end
      if (k < 5) @(negedge clk);
    end
  endtask

  task automatic doStep(input logic [1:0] d, input logic [1:0] resp);
    int nd, hx, hy, nx, ny;
    bit grow, erase;
    applyStimulus(d, resp);
    if (mDead) begin
      checkOutput("deadRen", rEnV, 0);
      checkOutput("deadWen", wEnV, 0);
      checkOutput("deadOver", game_over, 1);
      return;
    end
    nd = (int'(d) == (mDir ^ 2)) ? mDir : int'(d);
    hx = mBodyX[$];
    hy = mBodyY[$];
    nx = hx;
    ny = hy;
    case (nd)
      0: nx = (hx + 1) % 40;
      1: ny = (hy + 1) % 30;
      2: nx = (hx + 39) % 40;
      default: ny = (hy + 29) % 30;
    endcase
    mDir = nd;
    checkOutput("readStrobe", rEnV, 6'b000001);
    checkOutput("readX", rdX, nx);
    checkOutput("readY", rdY, ny);
    if (resp[0]) begin
      checkOutput("dieWen", wEnV, 0);
      checkOutput("dieOver", game_over, 1);
      checkOutput("dieBusy", busy, 0);
      mDead = 1'b1;
      return;
    end
    grow = (resp == 2'b10);
    erase = !grow || (mBodyX.size() == 64);
    checkOutput("writeStrobe", wEnV, erase ? 6'b011000 : 6'b001000);
    checkOutput("fruitPulse", feV, grow ? 6'b000100 : 6'b000000);
    checkOutput("headX", hwX, nx);
    checkOutput("headY", hwY, ny);
    checkOutput("headData", hwD, 1);
    if (erase) begin
      checkOutput("tailX", twX, mBodyX[0]);
      checkOutput("tailY", twY, mBodyY[0]);
      checkOutput("tailData", twD, 0);
      void'(mBodyX.pop_front());
      void'(mBodyY.pop_front());
    end
    mBodyX.push_back(nx);
    mBodyY.push_back(ny);
    if (grow && mScore < 255) mScore++;
    checkOutput("length", length, mBodyX.size());
    checkOutput("score", score, mScore);
    checkOutput("over", game_over, 0);
    checkOutput("idleBusy", busy, 0);
  endtask

  initial begin
    rstN = 1'b0;
    tick = 1'b0;
    dirIn = 2'b00;
    respVal = 2'b00;
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    rstN = 1'b1;
    runClear();

    doStep(2'b00, 2'b00);
    doStep(2'b10, 2'b00);
    while (mBodyX[$] != 39) doStep(2'b00, 2'b00);
    doStep(2'b00, 2'b00);
    checkOutput("wrapRight", mBodyX[$], 0);
    doStep(2'b11, 2'b00);
    while (mBodyY[$] != 0) doStep(2'b11, 2'b00);
    doStep(2'b11, 2'b00);
    checkOutput("wrapUp", mBodyY[$], 29);

    doStep(2'b11, 2'b10);
    checkOutput("firstFruitScore", score, 1);
    checkOutput("firstFruitLen", length, 4);
    while (mBodyX.size() < 64) doStep(2'b11, 2'b10);
    doStep(2'b11, 2'b10);
    checkOutput("fullLen", length, 64);

    doStep(2'b11, 2'b11);
    doStep(2'b00, 2'b00);

    @(negedge clk);
    rstN = 1'b0;
    repeat (2) @(negedge clk);
    checkResetValues("reset2");
    rstN = 1'b1;
    runClear();

    @(negedge clk);
    tick = 1'b1;
    dirIn = 2'b00;
    respVal = 2'b00;
    @(posedge clk);
    @(negedge clk);
    tick = 1'b0;
    checkOutput("midStepRen", update_renable, 1);
    #2 rstN = 1'b0;
    #1 checkResetValues("midReset");
    @(negedge clk);
    rstN = 1'b1;
    runClear();

    doStep(2'b01, 2'b01);
    doStep(2'b01, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
